mux_scan_n: RTL
===============

Name: mux_scan_n

Overview:
Parametrised N-channel registered multiplexer. It generalises the team's fixed 16:1 combinational mux to any channel count and data width, and adds two modes:
- Manual mode: an external select picks the channel.
- Scan mode: a time-division scanner visits every channel enabled by a mask, holding each for a programmable number of cycles.
It sits between parallel sensor/data lanes and a single serial consumer, and reports which channel is on the output.

Parameters:
N_CH, 16, number of input channels (2..64; power of two not required)
DW, 1, data width per channel in bits
DWELL, 1, cycles each channel is held in scan mode (>=1)
SW, $clog2(N_CH), select/index width; localparam derived from N_CH, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; 0 = hold output, deassert y_valid
mode  in  1  0 = manual select, 1 = auto scan
sel  in  SW  channel index in manual mode
ch_mask  in  N_CH  per-channel enable used in scan mode
d  in  N_CH*DW  packed inputs; channel k = d[k*DW +: DW]
y  out  DW  registered selected data
y_ch  out  SW  index of channel currently driven on y
y_valid  out  1  y/y_ch hold a valid selection
scan_wrap  out  1  one-cycle pulse when the scan pointer wraps to a lower index

Behaviour:
- Reset (async assert, sync release): y=0, y_ch=0, y_valid=0, scan_wrap=0, ptr=0, dwell_cnt=0, state=IDLE.
- Latency: outputs are registered. y/y_ch/y_valid reflect sel, d, mask and mode sampled on the previous edge (1 cycle).
- State machine:
  - IDLE: entered when en=0. y/y_ch hold, y_valid=0.
  - MANUAL: entered when en=1 & mode=0.
  - SCAN: entered when en=1 & mode=1.
  - Transitions are evaluated every cycle from en/mode and take effect the next cycle.
- MANUAL:
  - y=d[sel], y_ch=sel, y_valid=1. ch_mask is ignored.
  - sel>=N_CH (non-power-of-two N_CH): y=0, y_ch=sel, y_valid=0.
- SCAN:
  - Output: y=d[ptr], y_ch=ptr, y_valid=1.
  - Dwell: dwell_cnt counts 0..DWELL-1. At DWELL-1, ptr advances to the next set mask bit above ptr, wrapping modulo N_CH, and dwell_cnt clears.
  - Single enabled channel: ptr stays put, dwell_cnt still cycles, and scan_wrap pulses each dwell period.
  - Wrap: scan_wrap=1 for exactly the cycle y_ch first shows the new index when new ptr <= old ptr.
  - ch_mask == 0: y_valid=0, ptr and dwell_cnt hold, y holds.
  - Current ptr masked off mid-dwell: advance to the next enabled channel on the next edge regardless of dwell_cnt; dwell_cnt clears.
  - Entering SCAN from MANUAL/IDLE: if ch_mask[ptr]=1, scanning starts at ptr with dwell_cnt=0; otherwise at the next enabled channel above ptr.
  - ptr loads sel whenever in MANUAL, so a scan started after manual mode continues from the last manual channel.
- SCAN->MANUAL or ->IDLE: switches on the next edge; dwell_cnt clears.
- Data changes on d while the channel is held propagate every cycle, with 1-cycle latency.
- Reset asserted mid-scan: all outputs clear immediately (asynchronously). After release, first valid output is one cycle after en=1.

Decomposition:
- Shared package mux_pkg:
  - state enum {IDLE, MANUAL, SCAN}
  - function clog2_min1 (returns >=1)
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1
- One sub-module: next_ch_finder, a combinational rotating priority encoder.
  - Inputs: ch_mask, ptr.
  - Outputs: next index, found flag, wrap flag.
- The top instantiates next_ch_finder once and holds the FSM, dwell counter and output registers.

Test Plan:
- Manual sweep (N_CH=16, DW=1, DWELL=1): d=16'hA5C3, en=1, mode=0, sel=0..15 one per cycle -> y one cycle later = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; y_valid=1 throughout.
- Scan with gaps (DWELL=2): ch_mask=16'h0111, mode=1 -> y_ch = 0,0,4,4,8,8,0,0,...; scan_wrap=1 only on each first cycle of y_ch=0 after 8.
- Empty and dropped mask: while scanning on ch 4, ch_mask 16'h0111->16'h0101 -> y_ch=8 next cycle. Then ch_mask=0 -> y_valid=0 next cycle, y_ch stays 8.
- Mode switch: scanning, then mode=0, sel=5 -> y_ch=5 next cycle. Back to mode=1 with ch_mask=16'h0020 -> stays on 5 with y_valid=1; scan_wrap pulses every DWELL cycles.
- Non-power-of-two (N_CH=10, DW=4): sel=9, channel 9 = 4'hE -> y=4'hE, valid=1. Then sel=12 -> y=0, y_valid=0.
- Async reset mid-scan: rst_n low between clock edges -> y, y_ch, y_valid, scan_wrap all 0 before the next edge. After release with en=1, mode=1, ch_mask=16'h0111 -> first valid output on ch 0 one cycle later.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning multiplexer and its channel finder.
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width that never collapses to zero bits for tiny counts.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/next_ch_finder.sv
// Rotating priority encoder: lowest enabled channel strictly above ptr,
// falling back to the lowest enabled channel overall (a wrap).
module next_ch_finder
   import mux_pkg::*;
#(
   parameter int  N_CH = 16,
   localparam int SW   = clog2_min1(N_CH)
) (
   input  logic [N_CH-1:0] ch_mask,
   input  logic [SW-1:0]   ptr,
   output logic [SW-1:0]   next_ch,
   output logic            found,
   output logic            wrap
);

   logic [SW-1:0] hi_ch;
   logic [SW-1:0] lo_ch;
   logic          hi_found;

   // Descending scan so the last hit written is the lowest index.
   always_comb begin
      hi_ch    = '0;
      lo_ch    = '0;
      hi_found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            lo_ch = SW'(i);
            if (i > int'(ptr)) begin
               hi_ch    = SW'(i);
               hi_found = 1'b1;
            end
         end
      end
   end

   assign found   = |ch_mask;
   assign next_ch = hi_found ? hi_ch : lo_ch;
   assign wrap    = found & ~hi_found;

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and masked round-robin scan.
// Handshake: y/y_ch carry a selection only in cycles where y_valid=1; there is no back-pressure.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int  N_CH  = 16,
   parameter int  DW    = 1,
   parameter int  DWELL = 1,
   localparam int SW    = clog2_min1(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic [SW-1:0]        sel,
   input  logic [N_CH-1:0]      ch_mask,
   input  logic [N_CH*DW-1:0]   d,
   output logic [DW-1:0]        y,
   output logic [SW-1:0]        y_ch,
   output logic                 y_valid,
   output logic                 scan_wrap
);

   localparam int            CW         = clog2_min1(DWELL);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

   state_t        state, next_state;
   logic [SW-1:0] ptr, ptr_d;
   logic [CW-1:0] dwell_cnt, dwell_d;
   logic [DW-1:0] y_d;
   logic [SW-1:0] y_ch_d, tgt;
   logic          valid_d, wrap_d, advance;
   logic          sel_ok, ptr_enabled;
   logic [SW-1:0] nxt_ch;
   logic          nxt_found, nxt_wrap;
   logic [DW-1:0] d_arr [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign d_arr[k] = d[k*DW +: DW];
   end

   // sel and ptr may exceed N_CH-1 when N_CH is not a power of two.
   always_comb begin
      sel_ok      = int'(sel) < N_CH;
      ptr_enabled = 1'b0;
      if (int'(ptr) < N_CH) ptr_enabled = ch_mask[ptr];
   end

   next_ch_finder #(.N_CH(N_CH)) u_finder (
      .ch_mask (ch_mask),
      .ptr     (ptr),
      .next_ch (nxt_ch),
      .found   (nxt_found),
      .wrap    (nxt_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = IDLE;
      if (en) next_state = (mode == MODE_SCAN) ? SCAN : MANUAL;
   end

   // Next register values follow the mode sampled this edge; state tells us
   // whether scanning was already under way (dwell counting) or just starting.
   always_comb begin
      y_d     = y;
      y_ch_d  = y_ch;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      ptr_d   = ptr;
      dwell_d = '0;
      advance = 1'b0;
      tgt     = ptr;
      unique case (next_state)
         MANUAL: begin
            ptr_d   = sel;
            y_ch_d  = sel;
            valid_d = sel_ok;
            y_d     = sel_ok ? d_arr[sel] : '0;
         end
         SCAN: begin
            if (nxt_found) begin
               advance = !ptr_enabled || (state == SCAN && dwell_cnt == DWELL_LAST);
               if (advance) begin
                  tgt    = nxt_ch;
                  wrap_d = nxt_wrap;
               end else if (state == SCAN) begin
                  dwell_d = dwell_cnt + 1'b1;
               end
               ptr_d   = tgt;
               y_d     = d_arr[tgt];
               y_ch_d  = tgt;
               valid_d = 1'b1;
            end else begin
               dwell_d = dwell_cnt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= '0;
         y_ch      <= '0;
         y_valid   <= 1'b0;
         scan_wrap <= 1'b0;
         ptr       <= '0;
         dwell_cnt <= '0;
      end else begin
         y         <= y_d;
         y_ch      <= y_ch_d;
         y_valid   <= valid_d;
         scan_wrap <= wrap_d;
         ptr       <= ptr_d;
         dwell_cnt <= dwell_d;
      end
   end

endmodule
